// File: rtl/nibble_packer.sv
// Pairs consecutive 16-bit half-words into 32-bit words, buffers them in a
// DEPTH-entry FIFO and presents them on a valid/ready interface.
module nibble_packer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RESET_L,
  input  logic [3:0][3:0]      NIBBLE_IN,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic                 FLUSH,
  output logic [31:0]          DATA_OUT,
  output logic                 PAD_OUT,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [PTR_W:0]       FIFO_COUNT,
  output logic [15:0]          WORD_COUNT
);

  typedef enum logic {
    EMPTY_HALF = 1'b0,
    HAVE_LOW   = 1'b1
  } state_t;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_run;
  logic [15:0]      r_low;
  logic [32:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [15:0]      r_word_count;

  logic             w_not_full;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_out_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_load_low;
  logic [32:0]      w_push_entry;
  logic [32:0]      w_head;

  // Ready depends only on registered state, so a pop on a full FIFO frees
  // space for an accept one cycle later, not in the same cycle.
  assign w_not_full  = (r_count != FULL_COUNT);
  assign w_in_ready  = r_run & ((r_state == EMPTY_HALF) | w_not_full);
  assign w_accept    = IN_VALID & w_in_ready;
  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid & OUT_READY;
  assign w_head      = r_mem[r_rd_ptr];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_nxt  = r_state;
    w_push       = 1'b0;
    w_load_low   = 1'b0;
    w_push_entry = '0;
    case (r_state)
      EMPTY_HALF: begin
        if (w_accept) begin
          w_load_low  = 1'b1;
          w_state_nxt = HAVE_LOW;
        end
      end
      HAVE_LOW: begin
        if (w_accept) begin
          w_push       = 1'b1;
          w_push_entry = {1'b0, NIBBLE_IN, r_low};
          w_state_nxt  = EMPTY_HALF;
        end else if (FLUSH && w_not_full) begin
          w_push       = 1'b1;
          w_push_entry = {1'b1, 16'h0000, r_low};
          w_state_nxt  = EMPTY_HALF;
        end
      end
      default: w_state_nxt = EMPTY_HALF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      r_state      <= EMPTY_HALF;
      r_run        <= 1'b0;
      r_low        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_word_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
      if (w_load_low) r_low <= NIBBLE_IN;
      if (w_push)     r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + 1'b1;
        r_word_count <= r_word_count + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by the count
  // and pointers, and outputs are masked while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_entry;
  end

  assign IN_READY   = w_in_ready;
  assign OUT_VALID  = w_out_valid;
  assign DATA_OUT   = w_out_valid ? w_head[31:0] : 32'h0;
  assign PAD_OUT    = w_out_valid & w_head[32];
  assign FIFO_COUNT = r_count;
  assign WORD_COUNT = r_word_count;

endmodule

// File: tb/tb_nibble_packer.sv
// Scoreboard bench for nibble_packer: directed half-words push hand-computed
// words into a queue; a monitor compares every popped word against it.
module tb_nibble_packer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             CLK;
  logic             RESET_L;
  logic [3:0][3:0]  NIBBLE_IN;
  logic             IN_VALID;
  logic             IN_READY;
  logic             FLUSH;
  logic [31:0]      DATA_OUT;
  logic             PAD_OUT;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [PTR_W:0]   FIFO_COUNT;
  logic [15:0]      WORD_COUNT;

  int checks   = 0;
  int failures = 0;
  logic [32:0] sb[$];

  nibble_packer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .CLK        (CLK),
    .RESET_L    (RESET_L),
    .NIBBLE_IN  (NIBBLE_IN),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .FLUSH      (FLUSH),
    .DATA_OUT   (DATA_OUT),
    .PAD_OUT    (PAD_OUT),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .FIFO_COUNT (FIFO_COUNT),
    .WORD_COUNT (WORD_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic pad, input logic [31:0] data);
    sb.push_back({pad, data});
  endtask

  // Offer one half-word; returns 1 ns after the edge on which it was accepted.
  task automatic send(input logic [15:0] hw);
    bit ok = 1'b0;
    IN_VALID  = 1'b1;
    NIBBLE_IN = hw;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge CLK);
      ok = IN_READY;
      @(posedge CLK);
      #1;
    end
    IN_VALID = 1'b0;
    check("send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && FIFO_COUNT != 0; c++) cycle();
    check("drain_count", 64'(FIFO_COUNT), 64'd0);
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid and ready
  // are both high with reset released; the head must match the scoreboard.
  initial begin
    logic [32:0] exp_e;
    forever begin
      @(negedge CLK);
      if (RESET_L === 1'b1 && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_word", {31'h0, PAD_OUT, DATA_OUT}, 64'h1_FFFF_FFFF);
        end else begin
          exp_e = sb.pop_front();
          check("pop_data", 64'(DATA_OUT), 64'(exp_e[31:0]));
          check("pop_pad", 64'(PAD_OUT), 64'(exp_e[32]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RESET_L   = 1'b0;
    IN_VALID  = 1'b0;
    NIBBLE_IN = '0;
    FLUSH     = 1'b0;
    OUT_READY = 1'b0;

    // 1. reset hold and release
    repeat (3) @(posedge CLK);
    #1;
    check("rst_in_ready", 64'(IN_READY), 64'd0);
    check("rst_out_valid", 64'(OUT_VALID), 64'd0);
    RESET_L = 1'b1;
    cycle();
    check("rel_in_ready", 64'(IN_READY), 64'd1);
    check("rel_out_valid", 64'(OUT_VALID), 64'd0);
    check("rel_count", 64'(FIFO_COUNT), 64'd0);
    check("rel_data", 64'(DATA_OUT), 64'd0);
    check("rel_word_count", 64'(WORD_COUNT), 64'd0);

    // 2. basic pairing
    OUT_READY = 1'b1;
    expect_word(1'b0, 32'h3210BA98);
    send(16'hBA98);
    send(16'h3210);
    check("pair_valid", 64'(OUT_VALID), 64'd1);
    check("pair_data", 64'(DATA_OUT), 64'h3210BA98);
    check("pair_pad", 64'(PAD_OUT), 64'd0);
    cycle();
    check("pair_word_count", 64'(WORD_COUNT), 64'd1);

    // 3. flush of a lone low half, then flush with nothing pending
    expect_word(1'b1, 32'h000000C5);
    send(16'h00C5);
    FLUSH = 1'b1;
    cycle();
    FLUSH = 1'b0;
    check("flush_valid", 64'(OUT_VALID), 64'd1);
    check("flush_data", 64'(DATA_OUT), 64'h000000C5);
    check("flush_pad", 64'(PAD_OUT), 64'd1);
    FLUSH = 1'b1;
    cycle();
    FLUSH = 1'b0;
    cycle();
    check("flush_empty_count", 64'(FIFO_COUNT), 64'd0);
    check("flush_empty_valid", 64'(OUT_VALID), 64'd0);
    check("flush_word_count", 64'(WORD_COUNT), 64'd2);

    // 4. fill to full, back-pressure, drain across pointer wrap
    OUT_READY = 1'b0;
    expect_word(1'b0, 32'h10000001);
    expect_word(1'b0, 32'h20000002);
    expect_word(1'b0, 32'h30000003);
    expect_word(1'b0, 32'h40000004);
    expect_word(1'b0, 32'h50000005);
    send(16'h0001); send(16'h1000);
    send(16'h0002); send(16'h2000);
    send(16'h0003); send(16'h3000);
    send(16'h0004); send(16'h4000);
    send(16'h0005);
    check("full_count", 64'(FIFO_COUNT), 64'd4);
    check("full_in_ready", 64'(IN_READY), 64'd0);
    IN_VALID  = 1'b1;
    NIBBLE_IN = 16'h5000;
    OUT_READY = 1'b1;
    @(negedge CLK);
    check("full_pop_no_ready", 64'(IN_READY), 64'd0);
    cycle();
    check("ready_after_pop", 64'(IN_READY), 64'd1);
    check("count_after_pop", 64'(FIFO_COUNT), 64'd3);
    cycle();
    IN_VALID = 1'b0;
    check("count_push_pop", 64'(FIFO_COUNT), 64'd3);
    drain();
    check("wrap_word_count", 64'(WORD_COUNT), 64'd7);

    // 5. simultaneous push and pop at count 2; flush together with accept
    OUT_READY = 1'b0;
    expect_word(1'b0, 32'hA2A2A1A1);
    expect_word(1'b0, 32'hB2B2B1B1);
    expect_word(1'b0, 32'hC2C2C1C1);
    send(16'hA1A1); send(16'hA2A2);
    send(16'hB1B1); send(16'hB2B2);
    check("two_count", 64'(FIFO_COUNT), 64'd2);
    send(16'hC1C1);
    OUT_READY = 1'b1;
    send(16'hC2C2);
    check("simul_count", 64'(FIFO_COUNT), 64'd2);
    drain();
    expect_word(1'b0, 32'hA5A55A5A);
    send(16'h5A5A);
    FLUSH = 1'b1;
    send(16'hA5A5);
    FLUSH = 1'b0;
    repeat (3) cycle();
    check("flush_acc_count", 64'(FIFO_COUNT), 64'd0);
    check("flush_acc_sb", 64'(sb.size()), 64'd0);
    check("flush_acc_word_count", 64'(WORD_COUNT), 64'd11);

    // 6. reset mid-operation with three words queued and a pending low half
    OUT_READY = 1'b0;
    expect_word(1'b0, 32'h22221111);
    expect_word(1'b0, 32'h44443333);
    expect_word(1'b0, 32'h66665555);
    send(16'h1111); send(16'h2222);
    send(16'h3333); send(16'h4444);
    send(16'h5555); send(16'h6666);
    send(16'h7777);
    check("pre_rst_count", 64'(FIFO_COUNT), 64'd3);
    RESET_L   = 1'b0;
    OUT_READY = 1'b1;
    sb.delete();
    cycle();
    check("mid_rst_valid", 64'(OUT_VALID), 64'd0);
    check("mid_rst_data", 64'(DATA_OUT), 64'd0);
    check("mid_rst_pad", 64'(PAD_OUT), 64'd0);
    check("mid_rst_in_ready", 64'(IN_READY), 64'd0);
    check("mid_rst_count", 64'(FIFO_COUNT), 64'd0);
    check("mid_rst_word_count", 64'(WORD_COUNT), 64'd0);
    RESET_L = 1'b1;
    cycle();
    check("post_rst_in_ready", 64'(IN_READY), 64'd1);
    expect_word(1'b0, 32'hDEADBEEF);
    send(16'hBEEF);
    send(16'hDEAD);
    check("fresh_data", 64'(DATA_OUT), 64'hDEADBEEF);
    drain();
    check("fresh_word_count", 64'(WORD_COUNT), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_packer.md
Name: nibble_packer

Overview:
Downstream consumer of the 4-lane registered nibble selector. Each accepted cycle carries a 16-bit half-word of four nibbles. The block pairs consecutive half-words into 32-bit words and buffers them in a DEPTH-entry FIFO. Words are presented on a valid/ready output interface, and a FLUSH input emits a lone pending half-word as a zero-padded word.

Parameters:
DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESET_L  input  1  reset, synchronous, active-low.
NIBBLE_IN  input  [3:0][3:0]  four nibbles, 16 bits; lane i sits at half-word bits [4i+3:4i].
IN_VALID  input  1  NIBBLE_IN is valid this cycle.
IN_READY  output  1  block can accept NIBBLE_IN this cycle.
FLUSH  input  1  request to emit a pending low half-word, padded.
DATA_OUT  output  32  FIFO head word.
PAD_OUT  output  1  head word was flush-padded; bits [31:16] are zero.
OUT_VALID  output  1  FIFO not empty.
OUT_READY  input  1  downstream accepts DATA_OUT.
FIFO_COUNT  output  PTR_W+1  number of occupied entries, 0..DEPTH.
WORD_COUNT  output  16  words popped since reset; wraps 16'hFFFF to 0.

Behaviour:
- Definitions:
  - accept = IN_VALID & IN_READY.
  - pop = OUT_VALID & OUT_READY.
  - All updates happen on the CLK rising edge.
- Reset, while RESET_L is sampled low:
  - FSM goes to EMPTY_HALF; low register, pointers, FIFO_COUNT and WORD_COUNT clear to 0.
  - Outputs: OUT_VALID=0, DATA_OUT=0, PAD_OUT=0, IN_READY=0.
  - Reset mid-operation discards the pending half and all FIFO contents. No pop occurs on that cycle.
  - IN_READY=1 on the first cycle after release.
- FSM, two states. Transitions use the state at the start of the cycle.
  - EMPTY_HALF, on accept: NIBBLE_IN is stored in the low register, go to HAVE_LOW. No push.
  - HAVE_LOW, on accept: push word {NIBBLE_IN, low} with pad=0, go to EMPTY_HALF.
  - HAVE_LOW, FLUSH=1, no accept, FIFO_COUNT<DEPTH: push {16'h0000, low} with pad=1, go to EMPTY_HALF.
  - FLUSH in EMPTY_HALF is ignored.
  - FLUSH together with accept in HAVE_LOW: the full word is pushed, no padded word is created.
  - FLUSH while the FIFO is full is ignored; the requester holds FLUSH until it takes effect.
- IN_READY:
  - EMPTY_HALF: 1.
  - HAVE_LOW: (FIFO_COUNT<DEPTH).
  - Derived from registers only; no combinational path from OUT_READY or IN_VALID.
  - A pop on a full FIFO does not enable a same-cycle accept; IN_READY rises the next cycle.
- FIFO:
  - Entries are 33 bits: data plus pad flag.
  - Write and read pointers increment mod DEPTH, wrapping from DEPTH-1 to 0.
  - FIFO_COUNT updates +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Simultaneous push and pop on an empty FIFO is impossible, since pop requires OUT_VALID.
  - A push into an empty FIFO appears on DATA_OUT/OUT_VALID the next cycle (1-cycle latency).
- Output presentation:
  - DATA_OUT and PAD_OUT are the head entry when OUT_VALID=1, and 0 otherwise.
  - Head data is held stable while OUT_VALID=1 and OUT_READY=0.
- WORD_COUNT increments on each pop, modulo 2^16.
- Throughput: one word per two accepts. Input can sustain IN_VALID=1 every cycle with OUT_READY=1 and never stall.

Test Plan:
1. Reset hold 3 cycles, release → IN_READY=1, OUT_VALID=0, FIFO_COUNT=0, DATA_OUT=0.
2. Accept 16'hBA98, then 16'h3210, with OUT_READY=1 → one cycle after the second accept: DATA_OUT=32'h3210BA98, PAD_OUT=0, OUT_VALID=1; after the pop, WORD_COUNT=1.
3. Accept 16'h00C5, then FLUSH=1 with IN_VALID=0 → DATA_OUT=32'h000000C5, PAD_OUT=1. FLUSH in EMPTY_HALF produces no push.
4. OUT_READY=0, stream 10 half-words → FIFO_COUNT=4 and IN_READY=0 while holding a fifth low half. Raise OUT_READY → words drain in order, covering pointer wrap, and IN_READY returns the cycle after the first pop.
5. FIFO_COUNT=2, simultaneous push and pop → FIFO_COUNT stays 2 and order is preserved. FLUSH together with accept in HAVE_LOW → only the unpadded word is pushed.
6. Assert RESET_L=0 with FIFO_COUNT=3 and HAVE_LOW → next cycle all outputs are 0. The pending half is discarded: the next two accepts form a fresh word.
